// File: rtl/tick_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tick_timer_pkg
// Description : Shared types and constants for the tick timer block.
// Revision    : 1.0 - initial release
// ============================================================================
package tick_timer_pkg;

    // Default width of the reload value and the tick counter
    localparam int c_default_width = 32;

    // Fewest synchroniser flops allowed on the divided-clock input
    localparam int c_min_sync_stages = 2;

    // Timer control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : tick_timer_pkg
`default_nettype wire

// File: rtl/tick_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : tick_timer_if
// Description : Control/status bundle between a timer user and tick_timer.
// Revision    : 1.0 - initial release
// ============================================================================
interface tick_timer_if
    import tick_timer_pkg::*;
#(
    parameter int WIDTH = c_default_width
) ();

    logic             i_ENABLE;
    logic             i_ONE_SHOT;
    logic             i_LOAD;
    logic [WIDTH-1:0] i_RELOAD;
    logic             o_TICK;
    logic [WIDTH-1:0] o_COUNT;
    logic             o_EXPIRE;
    logic             o_RUNNING;

    // Side that controls the timer and watches its status
    modport master (
        output i_ENABLE, i_ONE_SHOT, i_LOAD, i_RELOAD,
        input  o_TICK, o_COUNT, o_EXPIRE, o_RUNNING
    );

    // The timer itself
    modport slave (
        input  i_ENABLE, i_ONE_SHOT, i_LOAD, i_RELOAD,
        output o_TICK, o_COUNT, o_EXPIRE, o_RUNNING
    );

endinterface : tick_timer_if
`default_nettype wire

// File: rtl/tick_timer_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : edge_sync
// Description : Synchronises an asynchronous level into the system clock
//               domain and emits a registered one-cycle pulse per rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_sync
    import tick_timer_pkg::*;
#(
    parameter int SYNC_STAGES = c_min_sync_stages
) (
    input  wire logic i_SYS_CLOCK,
    input  wire logic i_RESET_N,
    input  wire logic i_ASYNC,
    output logic      o_RISE
);

    // A chain shorter than the minimum is quietly lengthened
    localparam int c_stages = (SYNC_STAGES < c_min_sync_stages) ? c_min_sync_stages : SYNC_STAGES;

    logic [c_stages-1:0] sync_q, sync_d;
    // Marks which chain positions hold a real post-reset sample rather than
    // the reset value, so a zero left over from reset cannot prime the detector.
    logic [c_stages-1:0] vld_q, vld_d;
    logic                edge_q, edge_d;
    logic                primed_q, primed_d;
    logic                rise_q, rise_d;

    // Shift the input through the chain and form the rising-edge pulse
    always_comb begin
        sync_d   = {sync_q[c_stages-2:0], i_ASYNC};
        vld_d    = {vld_q[c_stages-2:0], 1'b1};
        edge_d   = sync_q[c_stages-1];
        primed_d = primed_q | (vld_q[c_stages-1] & ~sync_q[c_stages-1]);
        rise_d   = primed_q & sync_q[c_stages-1] & ~edge_q;
    end

    // Register the chain, history, primed flag and pulse
    always_ff @(posedge i_SYS_CLOCK) begin
        if (!i_RESET_N) begin
            sync_q   <= '0;
            vld_q    <= '0;
            edge_q   <= 1'b0;
            primed_q <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            vld_q    <= vld_d;
            edge_q   <= edge_d;
            primed_q <= primed_d;
            rise_q   <= rise_d;
        end
    end

    assign o_RISE = rise_q;

endmodule : edge_sync
`default_nettype wire

// File: rtl/tick_timer.sv
`default_nettype none
// ============================================================================
// Module      : tick_timer
// Description : Programmable down-counter of divided-clock ticks with
//               periodic and one-shot expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_timer
    import tick_timer_pkg::*;
#(
    parameter int WIDTH       = c_default_width,
    parameter int SYNC_STAGES = c_min_sync_stages
) (
    input  wire logic    i_SYS_CLOCK,
    input  wire logic    i_RESET_N,
    input  wire logic    i_TICK_CLOCK,
    tick_timer_if.slave  bus
);

    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_zero = '0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             expire_q, expire_d;
    logic             w_tick;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .i_SYS_CLOCK (i_SYS_CLOCK),
        .i_RESET_N   (i_RESET_N),
        .i_ASYNC     (i_TICK_CLOCK),
        .o_RISE      (w_tick)
    );

    // Next state, count and expiry; a load overrides everything else
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        expire_d = 1'b0;

        if (bus.i_LOAD) begin
            count_d  = bus.i_RELOAD;
            reload_d = bus.i_RELOAD;
            state_d  = (bus.i_ENABLE && (bus.i_RELOAD != c_zero)) ? RUN : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_ENABLE && (count_q != c_zero)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    // Disabling wins over a coincident tick, which is lost
                    if (!bus.i_ENABLE) begin
                        state_d = IDLE;
                    end else if (w_tick) begin
                        if (count_q > c_one) begin
                            count_d = count_q - c_one;
                        end else if (count_q == c_one) begin
                            expire_d = 1'b1;
                            if (bus.i_ONE_SHOT) begin
                                count_d = c_zero;
                                state_d = DONE;
                            end else begin
                                count_d = reload_q;
                            end
                        end
                    end
                end
                DONE: begin
                    if (!bus.i_ENABLE) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, counter, reload and expiry registers
    always_ff @(posedge i_SYS_CLOCK) begin
        if (!i_RESET_N) begin
            state_q  <= IDLE;
            count_q  <= c_zero;
            reload_q <= c_zero;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            expire_q <= expire_d;
        end
    end

    assign bus.o_TICK    = w_tick;
    assign bus.o_COUNT   = count_q;
    assign bus.o_EXPIRE  = expire_q;
    assign bus.o_RUNNING = (state_q == RUN);

endmodule : tick_timer
`default_nettype wire

// File: tb/tb_tick_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tick_timer
// Description : Self-checking bench for tick_timer with an event scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_timer;

    typedef struct {
        logic [31:0] count;
        logic        expire;
        logic        running;
    } ev_t;

    logic clk;
    logic rst_n;
    logic tick_clk;

    int   n_cmp;
    int   n_bad;
    int   cyc;

    ev_t  ev_q[$];
    int   tick_q[$];
    int   exp_cyc_q[$];

    logic        samp;
    logic        prev_samp;
    logic        have_prev;
    logic [31:0] last_count;
    logic        last_run;
    int          exp_t;
    ev_t         ev;

    tick_timer_if #(.WIDTH(32)) bus ();

    tick_timer #(
        .WIDTH       (32),
        .SYNC_STAGES (2)
    ) dut (
        .i_SYS_CLOCK  (clk),
        .i_RESET_N    (rst_n),
        .i_TICK_CLOCK (tick_clk),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_ev(input logic [31:0] c, input logic e, input logic r);
        ev_t x;
        x.count   = c;
        x.expire  = e;
        x.running = r;
        ev_q.push_back(x);
    endtask

    // Called at a falling edge; pulses i_LOAD for one cycle
    task automatic do_load(input logic [31:0] v, input logic en, input logic os);
        bus.i_RELOAD   = v;
        bus.i_ENABLE   = en;
        bus.i_ONE_SHOT = os;
        bus.i_LOAD     = 1'b1;
        @(negedge clk);
        bus.i_LOAD     = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (ev_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (ev_q.size() != 0) begin
            check_value({tag, "_timeout"}, ev_q.size(), 0);
            ev_q.delete();
        end
    endtask

    // Divided clock: toggles every cycle during reset, released high,
    // then a free-running 4-high / 4-low waveform
    initial begin
        tick_clk = 1'b0;
        repeat (5) begin
            @(negedge clk);
            tick_clk = ~tick_clk;
        end
        forever begin
            repeat (4) @(negedge clk);
            tick_clk = ~tick_clk;
        end
    end

    // Monitor: predicts tick timing from sampled input, scores output events
    initial begin
        cyc       = 0;
        have_prev = 1'b0;
        prev_samp = 1'b0;
        last_count = '0;
        last_run   = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            samp = tick_clk;
            if (!rst_n) begin
                have_prev = 1'b0;
            end else begin
                if (have_prev && !prev_samp && samp) tick_q.push_back(cyc + 2);
                prev_samp = samp;
                have_prev = 1'b1;
            end
            #1;
            if (!rst_n) begin
                last_count = bus.o_COUNT;
                last_run   = bus.o_RUNNING;
            end else begin
                if (bus.o_TICK) begin
                    if (tick_q.size() == 0) begin
                        check_value("tick_unexp", bus.o_TICK, 0);
                    end else begin
                        exp_t = tick_q.pop_front();
                        check_value("tick_cycle", cyc, exp_t);
                    end
                end else if (tick_q.size() > 0 && tick_q[0] < cyc) begin
                    void'(tick_q.pop_front());
                    check_value("tick_missed", bus.o_TICK, 1);
                end
                if (bus.o_EXPIRE) exp_cyc_q.push_back(cyc);
                if (bus.o_COUNT != last_count || bus.o_EXPIRE || bus.o_RUNNING != last_run) begin
                    if (ev_q.size() == 0) begin
                        check_value("ev_unexp_count", bus.o_COUNT, last_count);
                        check_value("ev_unexp_expire", bus.o_EXPIRE, 0);
                        check_value("ev_unexp_running", bus.o_RUNNING, last_run);
                    end else begin
                        ev = ev_q.pop_front();
                        check_value("ev_count", bus.o_COUNT, ev.count);
                        check_value("ev_expire", bus.o_EXPIRE, ev.expire);
                        check_value("ev_running", bus.o_RUNNING, ev.running);
                    end
                    last_count = bus.o_COUNT;
                    last_run   = bus.o_RUNNING;
                end
            end
        end
    end

    // Directed scenarios
    initial begin
        int n;
        n_cmp          = 0;
        n_bad          = 0;
        rst_n          = 1'b0;
        bus.i_ENABLE   = 1'b0;
        bus.i_ONE_SHOT = 1'b0;
        bus.i_LOAD     = 1'b0;
        bus.i_RELOAD   = '0;

        // Reset with the divided clock toggling underneath
        repeat (5) @(negedge clk);
        check_value("rst_tick", bus.o_TICK, 0);
        check_value("rst_count", bus.o_COUNT, 0);
        check_value("rst_expire", bus.o_EXPIRE, 0);
        check_value("rst_running", bus.o_RUNNING, 0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check_value("idle_count", bus.o_COUNT, 0);
        check_value("idle_running", bus.o_RUNNING, 0);

        // Periodic reload of 3
        push_ev(3, 0, 1); push_ev(2, 0, 1); push_ev(1, 0, 1); push_ev(3, 1, 1);
        push_ev(2, 0, 1); push_ev(1, 0, 1); push_ev(3, 1, 1);
        do_load(3, 1'b1, 1'b0);
        drain("periodic", 200);
        if (exp_cyc_q.size() == 2) check_value("expire_period", exp_cyc_q[1] - exp_cyc_q[0], 24);
        else check_value("periodic_expires", exp_cyc_q.size(), 2);
        check_value("periodic_running", bus.o_RUNNING, 1);
        exp_cyc_q.delete();

        // One-shot of 2, then ticks must change nothing
        push_ev(2, 0, 1); push_ev(1, 0, 1); push_ev(0, 1, 0);
        do_load(2, 1'b1, 1'b1);
        drain("oneshot", 100);
        repeat (32) @(negedge clk);
        check_value("oneshot_count", bus.o_COUNT, 0);
        check_value("oneshot_running", bus.o_RUNNING, 0);
        check_value("oneshot_expires", exp_cyc_q.size(), 1);
        exp_cyc_q.delete();

        // Pause at 5 for three tick periods
        push_ev(8, 0, 1); push_ev(7, 0, 1); push_ev(6, 0, 1); push_ev(5, 0, 1);
        do_load(8, 1'b1, 1'b0);
        drain("pause_run", 100);
        push_ev(5, 0, 0);
        bus.i_ENABLE = 1'b0;
        repeat (24) @(negedge clk);
        check_value("pause_count", bus.o_COUNT, 5);
        check_value("pause_running", bus.o_RUNNING, 0);
        push_ev(5, 0, 1); push_ev(4, 0, 1);
        bus.i_ENABLE = 1'b1;
        drain("resume", 60);

        // Load of 7 in the very cycle of the terminal tick
        push_ev(3, 0, 1); push_ev(2, 0, 1); push_ev(1, 0, 1);
        drain("to_one", 60);
        check_value("pre_collide_count", bus.o_COUNT, 1);
        n = 0;
        while (!bus.o_TICK && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_TICK) check_value("collide_tick_timeout", bus.o_TICK, 1);
        push_ev(7, 0, 1);
        do_load(7, 1'b1, 1'b0);
        check_value("collide_count", bus.o_COUNT, 7);
        repeat (3) @(negedge clk);
        check_value("collide_expires", exp_cyc_q.size(), 0);

        // Load of 0 with enable high forces IDLE
        push_ev(0, 0, 0);
        do_load(0, 1'b1, 1'b0);
        drain("load_zero", 20);
        repeat (20) @(negedge clk);
        check_value("zero_count", bus.o_COUNT, 0);
        check_value("zero_running", bus.o_RUNNING, 0);
        check_value("zero_expires", exp_cyc_q.size(), 0);
        check_value("ev_queue_left", ev_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_tick_timer
`default_nettype wire
